// File: rtl/adder_tree_accum.sv
// Accumulates pipelined adder-tree results into per-group sums, tracking valid/last through the tree latency.
// Optional saturation with sticky overflow flag when ADDER_ACCUM_SAT_EN is defined; otherwise wraps.
module adder_tree_accum #(
    parameter int N          = 32,
    parameter int DATA_WIDTH = 38,
    parameter int BEATS      = 4,
    parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(BEATS),
    parameter int CNT_WIDTH  = $clog2(BEATS + 1)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clock_ena,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic signed [DATA_WIDTH-1:0] tree_result,
    output logic                        out_valid,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0]        out_beats,
    output logic                        out_ovf
);

    localparam int DELAY = $clog2(N);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                       state_q, state_d;
    logic [DELAY-1:0]             vld_q, vld_d;
    logic [DELAY-1:0]             lst_q, lst_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic                         flag_q, flag_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [ACC_WIDTH-1:0]  out_sum_q, out_sum_d;
    logic [CNT_WIDTH-1:0]         out_beats_q, out_beats_d;
    logic                         out_ovf_q, out_ovf_d;

    logic                         d_valid;
    logic                         d_last;
    logic                         close;
    logic signed [ACC_WIDTH-1:0]  operand;
    logic signed [ACC_WIDTH-1:0]  base;
    logic signed [ACC_WIDTH-1:0]  raw_sum;
    logic signed [ACC_WIDTH-1:0]  next_sum;
    logic                         next_flag;

`ifdef ADDER_ACCUM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic                         ovf;
`endif

    always_comb begin
        d_valid = vld_q[DELAY-1];
        d_last  = lst_q[DELAY-1];
        operand = ACC_WIDTH'(tree_result);
        // Beat 0 of a group starts from zero instead of the stale accumulator.
        base    = (state_q == IDLE) ? '0 : acc_q;
        raw_sum = base + operand;
        close   = d_valid && (d_last || (cnt_q == CNT_WIDTH'(BEATS - 1)));
`ifdef ADDER_ACCUM_SAT_EN
        ovf       = (base[ACC_WIDTH-1] == operand[ACC_WIDTH-1]) &&
                    (raw_sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
        next_sum  = ovf ? (operand[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : raw_sum;
        next_flag = ((state_q == IDLE) ? 1'b0 : flag_q) | ovf;
`else
        next_sum  = raw_sum;
        next_flag = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        vld_d       = vld_q;
        lst_d       = lst_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        flag_d      = flag_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        if (clock_ena) begin
            vld_d[0] = in_valid;
            lst_d[0] = in_valid & in_last;
            for (int unsigned i = 1; i < DELAY; i++) begin
                vld_d[i] = vld_q[i-1];
                lst_d[i] = lst_q[i-1];
            end
            out_valid_d = close;
            if (d_valid) begin
                acc_d  = next_sum;
                flag_d = next_flag;
                if (close) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    out_sum_d   = next_sum;
                    out_beats_d = cnt_q + CNT_WIDTH'(1);
                    out_ovf_d   = next_flag;
                end else begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = ACCUM;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            lst_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Directed bench for adder_tree_accum: N=4 (tree latency 2), 8-bit results, 4 beats, 10-bit and 8-bit accumulators.
module tb_adder_tree_accum;

    logic                clock;
    logic                reset_n;
    logic                clock_ena;
    logic                in_valid;
    logic                in_last;
    logic signed [7:0]   in_data;
    logic signed [7:0]   dpipe [2];
    logic signed [7:0]   tree_result;

    logic                out_valid;
    logic signed [9:0]   out_sum;
    logic [2:0]          out_beats;
    logic                out_ovf;

    logic                s_valid;
    logic signed [7:0]   s_sum;
    logic [2:0]          s_beats;
    logic                s_ovf;

    int checks;
    int failures;

    adder_tree_accum #(
        .N(4), .DATA_WIDTH(8), .BEATS(4), .ACC_WIDTH(10), .CNT_WIDTH(3)
    ) u_dut (
        .clock(clock), .reset_n(reset_n), .clock_ena(clock_ena),
        .in_valid(in_valid), .in_last(in_last), .tree_result(tree_result),
        .out_valid(out_valid), .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf)
    );

    adder_tree_accum #(
        .N(4), .DATA_WIDTH(8), .BEATS(4), .ACC_WIDTH(8), .CNT_WIDTH(3)
    ) u_small (
        .clock(clock), .reset_n(reset_n), .clock_ena(clock_ena),
        .in_valid(in_valid), .in_last(in_last), .tree_result(tree_result),
        .out_valid(s_valid), .out_sum(s_sum), .out_beats(s_beats), .out_ovf(s_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the two-stage adder tree: data emerges two enabled edges after it is presented.
    always @(posedge clock) begin
        if (clock_ena) begin
            dpipe[1] <= dpipe[0];
            dpipe[0] <= in_data;
        end
    end
    assign tree_result = dpipe[1];

    task automatic cyc(input logic v, input logic l, input int d, input logic e);
        in_valid  = v;
        in_last   = l;
        in_data   = 8'(d);
        clock_ena = e;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom), 1'($urandom), int'($urandom_range(0, 255)), 1'($urandom));
            checks++;
            if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_beats !== 3'd0 || out_ovf !== 1'b0) begin
                $display("FAIL reset_main cyc=%0d got v=%b sum=%0d beats=%0d ovf=%b want all 0",
                         i, out_valid, out_sum, out_beats, out_ovf);
                failures++;
            end
            checks++;
            if (s_valid !== 1'b0 || s_sum !== 8'd0 || s_beats !== 3'd0 || s_ovf !== 1'b0) begin
                $display("FAIL reset_small cyc=%0d got v=%b sum=%0d beats=%0d ovf=%b want all 0",
                         i, s_valid, s_sum, s_beats, s_ovf);
                failures++;
            end
        end
        in_valid = 1'b0; in_last = 1'b0; clock_ena = 1'b1;
        reset_n = 1'b1;
        idle(3);
    endtask

    task automatic test_back_to_back();
        int d_tab [12] = '{10, 20, -5, 7, 1, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            cyc(i < 8, 1'b0, d_tab[i], 1'b1);
            checks++;
            if (out_valid !== (i == 5 || i == 9)) begin
                $display("FAIL b2b_valid cyc=%0d got %b want %b", i, out_valid, (i == 5 || i == 9));
                failures++;
            end
            if (i == 5 || i == 9) begin
                checks++;
                if (out_sum !== 10'((i == 5) ? 32 : 4) || out_beats !== 3'd4) begin
                    $display("FAIL b2b_sum cyc=%0d got sum=%0d beats=%0d want sum=%0d beats=4",
                             i, out_sum, out_beats, (i == 5) ? 32 : 4);
                    failures++;
                end
            end
        end
    endtask

    task automatic test_early_last();
        logic l_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int   d_tab [6] = '{100, 27, 5, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            cyc(i < 3, l_tab[i], d_tab[i], 1'b1);
            checks++;
            if (out_valid !== (i == 3 || i == 4)) begin
                $display("FAIL last_valid cyc=%0d got %b want %b", i, out_valid, (i == 3 || i == 4));
                failures++;
            end
        end
        idle(0);
    endtask

    task automatic test_early_last_values();
        cyc(1'b1, 1'b0, 100, 1'b1);
        cyc(1'b1, 1'b1, 27, 1'b1);
        cyc(1'b1, 1'b1, 5, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'd127 || out_beats !== 3'd2) begin
            $display("FAIL last_group1 got v=%b sum=%0d beats=%0d want v=1 sum=127 beats=2",
                     out_valid, out_sum, out_beats);
            failures++;
        end
        cyc(1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'd5 || out_beats !== 3'd1) begin
            $display("FAIL last_group2 got v=%b sum=%0d beats=%0d want v=1 sum=5 beats=1",
                     out_valid, out_sum, out_beats);
            failures++;
        end
        idle(3);
    endtask

    task automatic test_stall_gap();
        logic v_tab [20] = '{1,1,1,1,1,1,1,0,0,1,1,1,0,0,1,1,0,0,0,0};
        logic e_tab [20] = '{1,1,0,0,0,1,1,1,1,0,1,1,1,1,1,1,1,1,1,1};
        int   d_tab [20] = '{10,20,99,99,99,-5,7,0,0,99,1,1,0,0,1,1,0,0,0,0};
        logic want_v;
        for (int i = 0; i < 20; i++) begin
            cyc(v_tab[i], 1'b0, d_tab[i], e_tab[i]);
            want_v = (i == 8 || i == 9 || i == 17);
            checks++;
            if (out_valid !== want_v) begin
                $display("FAIL stall_valid cyc=%0d got %b want %b", i, out_valid, want_v);
                failures++;
            end
            if (want_v) begin
                checks++;
                if (out_sum !== 10'((i == 17) ? 4 : 32) || out_beats !== 3'd4) begin
                    $display("FAIL stall_sum cyc=%0d got sum=%0d beats=%0d want sum=%0d beats=4",
                             i, out_sum, out_beats, (i == 17) ? 4 : 32);
                    failures++;
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic signed [7:0] want_sum;
        logic              want_ovf;
`ifdef ADDER_ACCUM_SAT_EN
        want_sum = 8'sd127;
        want_ovf = 1'b1;
`else
        want_sum = -8'sd56;
        want_ovf = 1'b0;
`endif
        cyc(1'b1, 1'b0, 100, 1'b1);
        cyc(1'b1, 1'b1, 100, 1'b1);
        cyc(1'b1, 1'b1, 1, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_sum !== want_sum || s_ovf !== want_ovf || s_beats !== 3'd2) begin
            $display("FAIL ovf_small got v=%b sum=%0d ovf=%b beats=%0d want v=1 sum=%0d ovf=%b beats=2",
                     s_valid, s_sum, s_ovf, s_beats, want_sum, want_ovf);
            failures++;
        end
        checks++;
        if (out_sum !== 10'd200 || out_ovf !== 1'b0) begin
            $display("FAIL ovf_wide got sum=%0d ovf=%b want sum=200 ovf=0", out_sum, out_ovf);
            failures++;
        end
        cyc(1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_sum !== 8'sd1 || s_ovf !== 1'b0 || s_beats !== 3'd1) begin
            $display("FAIL ovf_clear got v=%b sum=%0d ovf=%b beats=%0d want v=1 sum=1 ovf=0 beats=1",
                     s_valid, s_sum, s_ovf, s_beats);
            failures++;
        end
        idle(3);
    endtask

    task automatic test_reset_mid_group();
        cyc(1'b1, 1'b0, 50, 1'b1);
        cyc(1'b1, 1'b0, 60, 1'b1);
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_beats !== 3'd0) begin
            $display("FAIL rst_async got v=%b sum=%0d beats=%0d want all 0", out_valid, out_sum, out_beats);
            failures++;
        end
        cyc(1'b0, 1'b0, 0, 1'b1);
        reset_n = 1'b1;
        for (int i = 3; i < 11; i++) begin
            cyc(i < 7, 1'b0, 1, 1'b1);
            checks++;
            if (out_valid !== (i == 8)) begin
                $display("FAIL rst_valid cyc=%0d got %b want %b", i, out_valid, (i == 8));
                failures++;
            end
            if (i == 8) begin
                checks++;
                if (out_sum !== 10'd4 || out_beats !== 3'd4) begin
                    $display("FAIL rst_sum got sum=%0d beats=%0d want sum=4 beats=4", out_sum, out_beats);
                    failures++;
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        clock_ena = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        test_reset();
        test_back_to_back();
        idle(3);
        test_early_last();
        test_early_last_values();
        test_stall_gap();
        test_overflow();
        test_reset_mid_group();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
